// File: rtl/serial_led_rx_if.sv
// Bundle between a serial LED transmitter (master) and the serial_led_rx receiver (slave).
interface serial_led_rx_if #(
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(WIDTH + 1) + 1;

   logic             s_clk;
   logic             s_dat;
   logic             s_clrn;
   logic             s_pen;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             frame_err;
   logic [7:0]       err_cnt;
   logic [CW-1:0]    bit_cnt;

   modport master (
      output s_clk, s_dat, s_clrn, s_pen,
      input  data_out, data_valid, frame_err, err_cnt, bit_cnt
   );

   modport slave (
      input  s_clk, s_dat, s_clrn, s_pen,
      output data_out, data_valid, frame_err, err_cnt, bit_cnt
   );
endinterface

// File: rtl/serial_led_rx.sv
// Oversampling receiver for the serial LED shift link: deserializes a WIDTH-bit frame and commits it on s_pen rise.
// Optional macro SERIAL_LED_RX_GLITCH_FILTER_EN adds a 2-sample stability filter on every synchronized line.
module serial_led_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input logic            clk,
   input logic            rst,
   serial_led_rx_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH + 1) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_MAX  = CW'(2 * WIDTH);
   localparam int            L_CLK    = 0;
   localparam int            L_DAT    = 1;
   localparam int            L_CLRN   = 2;
   localparam int            L_PEN    = 3;

   logic [3:0]       raw_s;
   logic [3:0]       sync_q [SYNC_STAGES];
   logic [3:0]       sync_s;
   logic [3:0]       line_q;
   logic [3:0]       line_d;
   logic [1:0]       hist_q;
   logic             clk_rise_s;
   logic             pen_rise_s;
   logic [WIDTH-1:0] shifted_s;

   logic [WIDTH-1:0] shreg_q,    shreg_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic [WIDTH-1:0] data_q,     data_d;
   logic             valid_q,    valid_d;
   logic             ferr_q,     ferr_d;
   logic [7:0]       err_cnt_q,  err_cnt_d;

   // Lines travel as one 4-bit vector so their relative alignment survives synchronization.
   assign raw_s = {bus.s_pen, bus.s_clrn, bus.s_dat, bus.s_clk};
   assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef SERIAL_LED_RX_GLITCH_FILTER_EN
   logic [3:0] prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 4'b0000;
      end else begin
         prev_q <= sync_s;
      end
   end

   always_comb begin
      line_d = line_q;
      for (int i = 0; i < 4; i++) begin
         if (sync_s[i] == prev_q[i]) begin
            line_d[i] = sync_s[i];
         end else begin
            line_d[i] = line_q[i];
         end
      end
   end
`else
   assign line_d = sync_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= 4'b0000;
         end
         line_q <= 4'b0000;
         hist_q <= 2'b00;
      end else begin
         sync_q[0] <= raw_s;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         line_q <= line_d;
         hist_q <= {line_q[L_PEN], line_q[L_CLK]};
      end
   end

   assign clk_rise_s = line_q[L_CLK] & ~hist_q[0];
   assign pen_rise_s = line_q[L_PEN] & ~hist_q[1];

   always_comb begin
      if (MSB_FIRST) begin
         shifted_s = {shreg_q[WIDTH-2:0], line_q[L_DAT]};
      end else begin
         shifted_s = {line_q[L_DAT], shreg_q[WIDTH-1:1]};
      end
   end

   // A coincident shift and latch: the latch judges the post-shift register and count.
   always_comb begin
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      err_cnt_d = err_cnt_q;
      if (!line_q[L_CLRN]) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else begin
         if (clk_rise_s) begin
            shreg_d = shifted_s;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end else begin
            shreg_d = shreg_q;
         end
         if (pen_rise_s) begin
            if (cnt_d == CNT_FULL) begin
               data_d  = shreg_d;
               valid_d = 1'b1;
            end else begin
               ferr_d = 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end else begin
                  err_cnt_d = err_cnt_q;
               end
            end
            cnt_d = '0;
         end else begin
            data_d = data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q   <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_serial_led_rx.sv
// Scoreboard bench for serial_led_rx: stimulus pushes expected latch events, a monitor pops them on data_valid/frame_err.
module tb_serial_led_rx;
   localparam int WIDTH = 16;
   localparam int HALF  = 5;

   typedef struct {
      logic        is_err;
      logic [15:0] data;
      logic [7:0]  ecnt;
   } exp_t;

   logic clk;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t exp_q[$];

   serial_led_rx_if #(.WIDTH(WIDTH)) bus ();

   serial_led_rx #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(2),
      .MSB_FIRST(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.s_dat = b;
      cyc(HALF);
      bus.s_clk = 1'b1;
      cyc(HALF);
      bus.s_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(w[i]);
      end
   endtask

   task automatic pulse_pen();
      bus.s_pen = 1'b1;
      cyc(HALF);
      bus.s_pen = 1'b0;
      cyc(HALF);
   endtask

   task automatic expect_evt(input logic is_err, input logic [15:0] data, input logic [7:0] ecnt);
      exp_t e;
      e.is_err = is_err;
      e.data   = data;
      e.ecnt   = ecnt;
      exp_q.push_back(e);
   endtask

   // Monitor: every latch outcome must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.data_valid || bus.frame_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", {30'd0, bus.data_valid, bus.frame_err}, e.is_err ? 32'd1 : 32'd2);
            chk("data_out", {16'd0, bus.data_out}, {16'd0, e.data});
            chk("err_cnt", {24'd0, bus.err_cnt}, {24'd0, e.ecnt});
         end
      end
   end

   initial begin
      rst        = 1'b1;
      bus.s_clk  = 1'b0;
      bus.s_dat  = 1'b0;
      bus.s_clrn = 1'b1;
      bus.s_pen  = 1'b0;
      cyc(5);
      rst = 1'b0;
      cyc(10);
      chk("reset_data_out", {16'd0, bus.data_out}, 32'd0);
      chk("reset_flags", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
      chk("reset_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      chk("reset_bit_cnt", {26'd0, bus.bit_cnt}, 32'd0);

      // Good frame
      send_bits(32'h0000_A5C3, 16);
      cyc(HALF);
      chk("good_bit_cnt", {26'd0, bus.bit_cnt}, 32'd16);
      expect_evt(1'b0, 16'hA5C3, 8'd0);
      pulse_pen();
      chk("good_bit_cnt_cleared", {26'd0, bus.bit_cnt}, 32'd0);

      // Short frame
      send_bits(32'h0000_1234, 15);
      cyc(HALF);
      chk("short_bit_cnt", {26'd0, bus.bit_cnt}, 32'd15);
      expect_evt(1'b1, 16'hA5C3, 8'd1);
      pulse_pen();

      // Long frame, last 16 bits 0x1234
      send_bits(32'h000F_1234, 20);
      cyc(HALF);
      chk("long_bit_cnt", {26'd0, bus.bit_cnt}, 32'd20);
      expect_evt(1'b1, 16'hA5C3, 8'd2);
      pulse_pen();
      chk("long_bit_cnt_cleared", {26'd0, bus.bit_cnt}, 32'd0);

      // Clear mid-frame
      send_bits(32'h0000_00AB, 8);
      cyc(HALF);
      chk("pre_clear_bit_cnt", {26'd0, bus.bit_cnt}, 32'd8);
      bus.s_clrn = 1'b0;
      cyc(4);
      bus.s_clrn = 1'b1;
      cyc(8);
      chk("clear_bit_cnt", {26'd0, bus.bit_cnt}, 32'd0);
      chk("clear_keeps_err_cnt", {24'd0, bus.err_cnt}, 32'd2);
      send_bits(32'h0000_FFFF, 16);
      expect_evt(1'b0, 16'hFFFF, 8'd2);
      pulse_pen();

      // 16th s_clk rise coincident with s_pen rise
      send_bits(32'h0000_6B2D >> 1, 15);
      bus.s_dat = 1'b1;
      cyc(HALF);
      expect_evt(1'b0, 16'h6B2D, 8'd2);
      bus.s_clk = 1'b1;
      bus.s_pen = 1'b1;
      cyc(HALF);
      bus.s_clk = 1'b0;
      bus.s_pen = 1'b0;
      cyc(HALF);
      chk("simul_bit_cnt_cleared", {26'd0, bus.bit_cnt}, 32'd0);

      // Reset mid-frame
      send_bits(32'h0000_00C3, 8);
      rst = 1'b1;
      cyc(3);
      chk("midrst_data_out", {16'd0, bus.data_out}, 32'd0);
      chk("midrst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      chk("midrst_bit_cnt", {26'd0, bus.bit_cnt}, 32'd0);
      rst = 1'b0;
      cyc(10);
      send_bits(32'h0000_0001, 16);
      expect_evt(1'b0, 16'h0001, 8'd0);
      pulse_pen();

      // Saturation: 300 empty frames
      for (int n = 1; n <= 300; n++) begin
         expect_evt(1'b1, 16'h0001, (n >= 255) ? 8'd255 : 8'(n));
         pulse_pen();
      end
      chk("err_cnt_saturated", {24'd0, bus.err_cnt}, 32'd255);

`ifdef SERIAL_LED_RX_GLITCH_FILTER_EN
      // One-cycle s_clk glitch inside a frame is filtered out
      send_bits(32'h0000_0055, 8);
      cyc(2);
      bus.s_clk = 1'b1;
      cyc(1);
      bus.s_clk = 1'b0;
      cyc(2);
      send_bits(32'h0000_0055, 8);
      cyc(HALF);
      chk("glitch_bit_cnt", {26'd0, bus.bit_cnt}, 32'd16);
      expect_evt(1'b0, 16'h5555, 8'd255);
      pulse_pen();
`endif

      cyc(20);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
